// File: rtl/sram_burst_reader_if.sv
// Command, SRAM read port and output stream of the burst reader, bundled as one bus.
interface sram_burst_reader_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 13
);

  // Burst command and status
  logic                  start_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic [LEN_WIDTH-1:0]  len_i;
  logic                  busy_o;
  logic                  done_o;

  // SRAM read port (registered read, one cycle after rden)
  logic                  rden_o;
  logic [ADDR_WIDTH-1:0] rdaddr_o;
  logic [DATA_WIDTH-1:0] rddata_i;

  // Output stream
  logic [DATA_WIDTH-1:0] dout_o;
  logic                  dout_valid_o;
  logic                  dout_ready_i;

  // Reader side
  modport slave (
    input  start_i,
    input  base_addr_i,
    input  len_i,
    output busy_o,
    output done_o,
    output rden_o,
    output rdaddr_o,
    input  rddata_i,
    output dout_o,
    output dout_valid_o,
    input  dout_ready_i
  );

  // Host / SRAM / sink side
  modport master (
    output start_i,
    output base_addr_i,
    output len_i,
    input  busy_o,
    input  done_o,
    input  rden_o,
    input  rdaddr_o,
    output rddata_i,
    input  dout_o,
    input  dout_valid_o,
    output dout_ready_i
  );

endinterface

// File: rtl/sram_burst_reader.sv
// Burst read controller: issues SRAM reads for a (base, len) command and streams
// the returned words through a 2-entry FIFO with valid/ready backpressure.
module sram_burst_reader #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LEN_WIDTH  = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_burst_reader_if.slave   bus
);

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned CNT_WIDTH  = 2;
  localparam int unsigned CRD_WIDTH  = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;

  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;
  logic [ADDR_WIDTH-1:0] r_rdaddr;
  logic                  r_pending;

  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  logic                  r_busy;
  logic                  r_done;

  logic                  w_accept;
  logic                  w_pop;
  logic                  w_push;
  logic [CRD_WIDTH-1:0]  w_credit_used;
  logic                  w_rden;
  logic                  w_last_issue;
  logic                  w_drained;

  // Handshake and credit bookkeeping
  assign w_accept      = (r_state == S_IDLE) && bus.start_i;
  assign w_pop         = (r_count != '0) && bus.dout_ready_i;
  assign w_push        = r_pending;
  assign w_credit_used = CRD_WIDTH'(r_count) + CRD_WIDTH'(r_pending) - CRD_WIDTH'(w_pop);

  // A read is issued only while a FIFO slot is guaranteed for its data
  assign w_rden        = (r_state == S_READ) && (r_issued < r_len)
                         && (w_credit_used < CRD_WIDTH'(FIFO_DEPTH));
  assign w_last_issue  = w_rden && ((r_issued + LEN_WIDTH'(1)) == r_len);

  // Burst is finished once nothing is in flight and the last word leaves this cycle
  assign w_drained     = !r_pending
                         && ((r_count == '0) || ((r_count == CNT_WIDTH'(1)) && w_pop));

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_i) begin
          w_state_nxt = (bus.len_i != '0) ? S_READ : S_FIN;
        end
      end
      S_READ: begin
        if (w_last_issue) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status flags: busy follows READ/DRAIN, done pulses once after FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_READ) || (w_state_nxt == S_DRAIN);
      r_done <= (r_state == S_FIN);
    end
  end

  // Command latch, issue counter and read address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len    <= '0;
      r_issued <= '0;
      r_rdaddr <= '0;
    end else if (w_accept) begin
      r_len    <= bus.len_i;
      r_issued <= '0;
      r_rdaddr <= bus.base_addr_i;
    end else if (w_rden) begin
      r_issued <= r_issued + LEN_WIDTH'(1);
      r_rdaddr <= r_rdaddr + ADDR_WIDTH'(1);
    end
  end

  // SRAM data is valid the cycle after a read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_rden;
    end
  end

  // Two-entry FIFO kept as head/tail registers so the head drives dout directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == '0) begin
            r_head <= bus.rddata_i;
          end else begin
            r_tail <= bus.rddata_i;
          end
          r_count <= r_count + CNT_WIDTH'(1);
        end
        2'b01: begin
          if (r_count == CNT_WIDTH'(2)) begin
            r_head <= r_tail;
          end
          r_count <= r_count - CNT_WIDTH'(1);
        end
        2'b11: begin
          if (r_count == CNT_WIDTH'(2)) begin
            r_head <= r_tail;
            r_tail <= bus.rddata_i;
          end else begin
            r_head <= bus.rddata_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output drive
  assign bus.busy_o       = r_busy;
  assign bus.done_o       = r_done;
  assign bus.rden_o       = w_rden;
  assign bus.rdaddr_o     = r_rdaddr;
  assign bus.dout_o       = r_head;
  assign bus.dout_valid_o = (r_count != '0);

endmodule

// File: tb/tb_sram_burst_reader.sv
// Self-checking bench for sram_burst_reader: SRAM model, randomized bursts and
// backpressure, scoreboard of expected addresses/words checked by a monitor.
module tb_sram_burst_reader;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 16;
  localparam int unsigned LW    = 13;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk;
  logic rst_n;

  sram_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  sram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM contents and registered read port
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (bus.rden_o) bus.rddata_i <= mem[bus.rdaddr_o];
  end

  int n_err    = 0;
  int n_checks = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues filled when a burst is issued
  logic [DW-1:0] exp_q  [$];
  logic [AW-1:0] addr_q [$];

  int issued_tot, popped_tot, n_done, done_cyc;
  int first_rden_cyc, first_valid_cyc, last_pop_cyc;
  int ready_mode;
  int rpat;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink ready generator: 0 = always, 1 = pattern 1,0,0, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.dout_ready_i = 1'b1;
      1: begin
        bus.dout_ready_i = (rpat == 0);
        rpat = (rpat + 1) % 3;
      end
      default: bus.dout_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares addresses/words against the scoreboard and watches stream rules
  bit            m_pop;
  int            m_out;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_dout;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_word;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      m_pop = bus.dout_valid_o && bus.dout_ready_i;
      m_out = issued_tot - popped_tot;
      check("held_words_le_2", longint'(m_out <= 2), 1);
      if (prev_stall) begin
        check("stall_valid_held", bus.dout_valid_o, 1);
        check("stall_data_held", bus.dout_o, prev_dout);
      end
      if (bus.rden_o) begin
        check("rden_only_when_busy", bus.busy_o, 1);
        check("rden_with_credit", longint'((m_out - int'(m_pop)) < 2), 1);
        check("rden_expected", longint'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) begin
          m_addr = addr_q.pop_front();
          check("rdaddr", bus.rdaddr_o, m_addr);
        end
        issued_tot++;
        if (first_rden_cyc < 0) first_rden_cyc = cyc;
      end
      if (m_pop) begin
        check("word_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          m_word = exp_q.pop_front();
          check("dout_word", bus.dout_o, m_word);
        end
        popped_tot++;
        last_pop_cyc = cyc;
      end
      if (bus.dout_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.done_o) begin
        n_done++;
        done_cyc = cyc;
      end
      prev_stall = bus.dout_valid_o && !bus.dout_ready_i;
      prev_dout  = bus.dout_o;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},   bus.busy_o, 0);
    check({tag, "_done"},   bus.done_o, 0);
    check({tag, "_rden"},   bus.rden_o, 0);
    check({tag, "_rdaddr"}, bus.rdaddr_o, 0);
    check({tag, "_dout"},   bus.dout_o, 0);
    check({tag, "_valid"},  bus.dout_valid_o, 0);
  endtask

  // Issue a command, fill the scoreboard, return the cycle stamp of cycle 1
  task automatic start_burst(input int base, input int len, output int t0);
    @(posedge clk); #1;
    for (int i = 0; i < len; i++) begin
      addr_q.push_back(AW'((base + i) % DEPTH));
      exp_q.push_back(mem[(base + i) % DEPTH]);
    end
    first_rden_cyc  = -1;
    first_valid_cyc = -1;
    bus.start_i     = 1'b1;
    bus.base_addr_i = AW'(base);
    bus.len_i       = LW'(len);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    t0 = cyc;
    check("busy_after_start", bus.busy_o, longint'(len > 0));
  endtask

  task automatic wait_done(input int done0, input int len, input bit timed, input int t0);
    int k = 0;
    int lim = 4 * len + 50;
    while (n_done == done0 && k < lim) begin
      @(posedge clk);
      k++;
    end
    check("done_seen", longint'(n_done > done0), 1);
    if (timed && len > 0) begin
      check("first_rden_cycle1", first_rden_cyc - t0 + 1, 1);
      check("first_valid_cycle3", first_valid_cyc - t0 + 1, 3);
      check("last_pop_cycle_n2", last_pop_cyc - t0 + 1, len + 2);
      check("done_cycle_n3_n4", longint'((done_cyc - t0 + 1 == len + 3) ||
                                         (done_cyc - t0 + 1 == len + 4)), 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("one_done_pulse", n_done, done0 + 1);
    check("busy_low_after", bus.busy_o, 0);
    check("words_all_out", exp_q.size(), 0);
    check("addrs_all_issued", addr_q.size(), 0);
  endtask

  task automatic run_burst(input int base, input int len, input int mode);
    int t0;
    int d0;
    ready_mode = mode;
    d0 = n_done;
    start_burst(base, len, t0);
    wait_done(d0, len, mode == 0, t0);
  endtask

  // Global time limit
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int d0;
    int i0;
    int p0;
    int k;
    clk             = 1'b0;
    rst_n           = 1'b0;
    bus.start_i     = 1'b0;
    bus.base_addr_i = '0;
    bus.len_i       = '0;
    bus.dout_ready_i = 1'b1;
    bus.rddata_i    = '0;
    ready_mode      = 0;
    rpat            = 0;
    issued_tot      = 0;
    popped_tot      = 0;
    n_done          = 0;
    done_cyc        = -1;
    first_rden_cyc  = -1;
    first_valid_cyc = -1;
    last_pop_cyc    = -1;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'($urandom);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Basic burst, ready always high, with latency checks
    run_burst(32'h010, 4, 0);

    // Backpressure pattern 1,0,0
    rpat = 0;
    run_burst(32'h100, 8, 1);

    // Address wrap
    run_burst(32'hFFE, 4, 0);

    // Zero length
    ready_mode = 0;
    d0 = n_done;
    i0 = issued_tot;
    start_burst(32'h333, 0, t0);
    wait_done(d0, 0, 1'b0, t0);
    check("zero_len_done_cycle2", done_cyc - t0 + 1, 2);
    check("zero_len_no_rden", issued_tot, i0);
    check("zero_len_no_valid", first_valid_cyc, -1);

    // Start pulsed while busy must be ignored
    ready_mode = 0;
    d0 = n_done;
    start_burst(32'h400, 16, t0);
    repeat (5) @(posedge clk);
    #1;
    bus.start_i     = 1'b1;
    bus.base_addr_i = AW'(32'h555);
    bus.len_i       = LW'(3);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done(d0, 16, 1'b0, t0);

    // Reset in the middle of a 10-word burst
    ready_mode = 0;
    d0 = n_done;
    p0 = popped_tot;
    start_burst(32'h200, 10, t0);
    k = 0;
    while (popped_tot - p0 < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("midreset_three_words", longint'(popped_tot - p0 >= 3), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    addr_q.delete();
    issued_tot = 0;
    popped_tot = 0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_no_done", n_done, d0);
    rst_n = 1'b1;
    run_burst(32'h020, 2, 0);

    // Randomized bursts
    for (int n = 0; n < 30; n++) begin
      rpat = 0;
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 40)),
                int'($urandom_range(0, 2)));
    end

    // Maximum-length burst with random backpressure
    run_burst(int'($urandom_range(0, DEPTH - 1)), int'(DEPTH), 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
